// File: rtl/selevy_ram_arbiter.sv
// Round-robin arbiter sharing the selevy single-port data RAM between the load/store unit
// (port 0) and a debug/DMA master (port 1); reads are held off until their data returns.
module selevy_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RAM_LAT    = 1
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int unsigned CntW = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

   typedef enum logic [0:0] {StIdle, StRdWait} state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              winner;
   logic              capture;

   // Last RD_WAIT cycle: ram_rdata is valid now and lands in the owner's register.
   assign capture = (state_q == StRdWait) && (cnt_q == CntW'(1));

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      winner    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (state_q)
         StIdle: begin
            if (!reset && (req0 || req1)) begin
               // On a tie the port that did not go last wins.
               winner    = (req0 && req1) ? ~last_q : req1;
               gnt0      = ~winner;
               gnt1      = winner;
               ram_en    = 1'b1;
               ram_we    = winner ? we1 : we0;
               ram_addr  = winner ? addr1 : addr0;
               ram_wdata = winner ? wdata1 : wdata0;
               last_d    = winner;
               if (!ram_we) begin
                  state_d = StRdWait;
                  cnt_d   = CntW'(RAM_LAT);
                  owner_d = winner;
               end
            end
         end
         StRdWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         rvalid0 <= capture && !owner_q;
         rvalid1 <= capture && owner_q;
         if (capture && !owner_q) begin
            rdata0 <= ram_rdata;
         end
         if (capture && owner_q) begin
            rdata1 <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_selevy_ram_arbiter.sv
// Bench for selevy_ram_arbiter: instance 0 uses RAM_LAT=1, instance 1 uses RAM_LAT=2.
// A timestamp-based transaction model checks every output of both instances each cycle.
module tb_selevy_ram_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        rq  [2][2];
   logic        we  [2][2];
   logic [7:0]  ad  [2][2];
   logic [31:0] wd  [2][2];
   logic        gnt [2][2];
   logic        rv  [2][2];
   logic [31:0] rd  [2][2];
   logic        ram_en    [2];
   logic        ram_we    [2];
   logic [7:0]  ram_addr  [2];
   logic [31:0] ram_wdata [2];
   logic [31:0] ram_rdata [2];

   selevy_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_LAT(1)) dut0 (
      .CLK(clk), .reset(rst),
      .req0(rq[0][0]), .we0(we[0][0]), .addr0(ad[0][0]), .wdata0(wd[0][0]),
      .gnt0(gnt[0][0]), .rvalid0(rv[0][0]), .rdata0(rd[0][0]),
      .req1(rq[0][1]), .we1(we[0][1]), .addr1(ad[0][1]), .wdata1(wd[0][1]),
      .gnt1(gnt[0][1]), .rvalid1(rv[0][1]), .rdata1(rd[0][1]),
      .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
      .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
   );

   selevy_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_LAT(2)) dut1 (
      .CLK(clk), .reset(rst),
      .req0(rq[1][0]), .we0(we[1][0]), .addr0(ad[1][0]), .wdata0(wd[1][0]),
      .gnt0(gnt[1][0]), .rvalid0(rv[1][0]), .rdata0(rd[1][0]),
      .req1(rq[1][1]), .we1(we[1][1]), .addr1(ad[1][1]), .wdata1(wd[1][1]),
      .gnt1(gnt[1][1]), .rvalid1(rv[1][1]), .rdata1(rd[1][1]),
      .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
      .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
   );

   // Behavioural RAMs: read data appears RAM_LAT cycles after the command cycle.
   logic [31:0] mem [2][256];
   logic [31:0] rp0 [2];
   logic [31:0] rp1;
   logic        mem_clr;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_clr) begin
            for (int a = 0; a < 256; a++) mem[i][a] <= '0;
         end else if (ram_en[i] && ram_we[i]) begin
            mem[i][ram_addr[i]] <= ram_wdata[i];
         end
         if (ram_en[i] && !ram_we[i]) rp0[i] <= mem[i][ram_addr[i]];
      end
      rp1 <= rp0[1];
   end
   assign ram_rdata[0] = rp0[0];
   assign ram_rdata[1] = rp1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endfunction

   // Reference model: one outstanding read with an absolute return cycle per instance.
   int          cyc = 0;
   int          m_last [2];
   bit          pend_v [2];
   int          pend_p [2];
   int          pend_c [2];
   logic [31:0] pend_d [2];
   logic [31:0] m_rd   [2][2];
   logic [31:0] shadow [2][256];
   bit          exp_gnt [2][2];

   function automatic void step(int i);
      int          lat;
      int          w;
      bit          e_rv [2];
      bit          e_g  [2];
      bit          e_en;
      bit          e_we;
      logic [7:0]  e_a;
      logic [31:0] e_d;
      lat = i + 1;
      e_rv[0] = 0; e_rv[1] = 0; e_g[0] = 0; e_g[1] = 0;
      e_en = 0; e_we = 0; e_a = '0; e_d = '0;
      if (rst) begin
         m_last[i] = 1;
         pend_v[i] = 0;
         m_rd[i][0] = '0;
         m_rd[i][1] = '0;
      end else begin
         if (pend_v[i] && cyc == pend_c[i]) begin
            e_rv[pend_p[i]] = 1;
            m_rd[i][pend_p[i]] = pend_d[i];
            pend_v[i] = 0;
         end
         if (!pend_v[i] && (rq[i][0] || rq[i][1])) begin
            if (rq[i][0] && rq[i][1]) w = 1 - m_last[i];
            else w = rq[i][1] ? 1 : 0;
            e_g[w] = 1; e_en = 1;
            e_we = we[i][w]; e_a = ad[i][w]; e_d = wd[i][w];
            m_last[i] = w;
            if (e_we) shadow[i][e_a] = e_d;
            else begin
               pend_v[i] = 1; pend_p[i] = w;
               pend_c[i] = cyc + lat + 1;
               pend_d[i] = shadow[i][e_a];
            end
         end
      end
      for (int p = 0; p < 2; p++) begin
         exp_gnt[i][p] = e_g[p];
         check($sformatf("i%0d c%0d gnt%0d", i, cyc, p), 32'(gnt[i][p]), 32'(e_g[p]));
         check($sformatf("i%0d c%0d rvalid%0d", i, cyc, p), 32'(rv[i][p]), 32'(e_rv[p]));
         check($sformatf("i%0d c%0d rdata%0d", i, cyc, p), rd[i][p], m_rd[i][p]);
      end
      check($sformatf("i%0d c%0d ram_en", i, cyc), 32'(ram_en[i]), 32'(e_en));
      check($sformatf("i%0d c%0d ram_we", i, cyc), 32'(ram_we[i]), 32'(e_we));
      check($sformatf("i%0d c%0d ram_addr", i, cyc), 32'(ram_addr[i]), 32'(e_a));
      check($sformatf("i%0d c%0d ram_wdata", i, cyc), ram_wdata[i], e_d);
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_last[i] = 1; pend_v[i] = 0; pend_p[i] = 0; pend_c[i] = 0; pend_d[i] = '0;
         for (int p = 0; p < 2; p++) begin
            m_rd[i][p] = '0;
            exp_gnt[i][p] = 0;
         end
         for (int a = 0; a < 256; a++) shadow[i][a] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) step(i);
      end
   end

   // Stimulus helpers.
   bit oneshot;

   task automatic tick();
      @(posedge clk);
      #1;
      if (oneshot) begin
         for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
               if (exp_gnt[i][p]) rq[i][p] = 1'b0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic put(int i, int p, bit w, logic [7:0] a, logic [31:0] d);
      rq[i][p] = 1'b1; we[i][p] = w; ad[i][p] = a; wd[i][p] = d;
   endtask

   task automatic put2(int p, bit w, logic [7:0] a, logic [31:0] d);
      put(0, p, w, a, d);
      put(1, p, w, a, d);
   endtask

   logic [31:0] e_dat [3];

   initial begin
      rst = 1'b1;
      mem_clr = 1'b1;
      oneshot = 1'b1;
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < 2; p++) begin
            rq[i][p] = 1'b0; we[i][p] = 1'b0; ad[i][p] = '0; wd[i][p] = '0;
         end
      e_dat[0] = 32'hE0E0_0004;
      e_dat[1] = 32'hE1E1_0005;
      e_dat[2] = 32'hE2E2_0006;
      tick();
      mem_clr = 1'b0;
      tick();
      settle();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst i%0d gnt0", i), 32'(gnt[i][0]), 32'd0);
         check($sformatf("rst i%0d ram_en", i), 32'(ram_en[i]), 32'd0);
         check($sformatf("rst i%0d rvalid1", i), 32'(rv[i][1]), 32'd0);
         check($sformatf("rst i%0d rdata0", i), rd[i][0], 32'd0);
      end

      // Test 1: single write right after reset release.
      tick();
      rst = 1'b0;
      put2(0, 1'b1, 8'h03, 32'hDEADBEEF);
      settle();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t1 i%0d gnt0", i), 32'(gnt[i][0]), 32'd1);
         check($sformatf("t1 i%0d ram_en", i), 32'(ram_en[i]), 32'd1);
         check($sformatf("t1 i%0d ram_we", i), 32'(ram_we[i]), 32'd1);
         check($sformatf("t1 i%0d ram_addr", i), 32'(ram_addr[i]), 32'h03);
      end
      tick();
      for (int i = 0; i < 2; i++)
         check($sformatf("t1 i%0d RAM[3]", i), mem[i][3], 32'hDEADBEEF);

      // Test 2: port 1 reads the word back.
      put2(1, 1'b0, 8'h03, 32'h0);
      settle();
      check("t2 i0 gnt1 at T", 32'(gnt[0][1]), 32'd1);
      tick(); settle();
      check("t2 i0 rvalid1 at T+1", 32'(rv[0][1]), 32'd0);
      check("t2 i0 ram_en at T+1", 32'(ram_en[0]), 32'd0);
      tick(); settle();
      check("t2 i0 rvalid1 at T+2", 32'(rv[0][1]), 32'd1);
      check("t2 i0 rdata1 at T+2", rd[0][1], 32'hDEADBEEF);
      check("t2 i0 rvalid0 at T+2", 32'(rv[0][0]), 32'd0);
      tick(); settle();
      check("t2 i0 rvalid1 at T+3", 32'(rv[0][1]), 32'd0);
      check("t2 i1 rvalid1 at T+3", 32'(rv[1][1]), 32'd1);
      check("t2 i1 rdata1 at T+3", rd[1][1], 32'hDEADBEEF);
      tick();

      // Test 3: continuous writes from both ports alternate.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      oneshot = 1'b0;
      put2(0, 1'b1, 8'h08, 32'hAAAA_0008);
      put2(1, 1'b1, 8'h09, 32'hBBBB_0009);
      for (int k = 0; k < 4; k++) begin
         settle();
         for (int i = 0; i < 2; i++) begin
            check($sformatf("t3 i%0d k%0d gnt0", i, k), 32'(gnt[i][0]), 32'(k % 2 == 0));
            check($sformatf("t3 i%0d k%0d gnt1", i, k), 32'(gnt[i][1]), 32'(k % 2 == 1));
            check($sformatf("t3 i%0d k%0d model", i, k), 32'(exp_gnt[i][k % 2]), 32'd1);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         rq[i][0] = 1'b0; rq[i][1] = 1'b0;
      end
      oneshot = 1'b1;
      tick();

      // Test 4: both ports read, RAM_LAT=2 instance.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      put2(0, 1'b0, 8'h08, 32'h0);
      put2(1, 1'b0, 8'h09, 32'h0);
      for (int k = 0; k < 8; k++) begin
         settle();
         check($sformatf("t4 k%0d gnt0", k), 32'(gnt[1][0]), 32'(k == 0));
         check($sformatf("t4 k%0d gnt1", k), 32'(gnt[1][1]), 32'(k == 3));
         check($sformatf("t4 k%0d ram_en", k), 32'(ram_en[1]), 32'(k == 0 || k == 3));
         check($sformatf("t4 k%0d rvalid0", k), 32'(rv[1][0]), 32'(k == 3));
         check($sformatf("t4 k%0d rvalid1", k), 32'(rv[1][1]), 32'(k == 6));
         if (k == 3) check("t4 rdata0", rd[1][0], 32'hAAAA_0008);
         if (k == 6) check("t4 rdata1", rd[1][1], 32'hBBBB_0009);
         tick();
      end

      // Test 5: reset while a read is in flight.
      put2(0, 1'b0, 8'h08, 32'h0);
      settle();
      for (int i = 0; i < 2; i++)
         check($sformatf("t5 i%0d gnt0 at T", i), 32'(gnt[i][0]), 32'd1);
      tick();
      rst = 1'b1;
      settle();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t5 i%0d gnt in reset", i), 32'(gnt[i][0] | gnt[i][1]), 32'd0);
         check($sformatf("t5 i%0d ram_en in reset", i), 32'(ram_en[i]), 32'd0);
         check($sformatf("t5 i%0d rdata0 in reset", i), rd[i][0], 32'd0);
      end
      tick();
      rst = 1'b0;
      put2(0, 1'b1, 8'h0A, 32'hC0C0_000A);
      put2(1, 1'b1, 8'h0B, 32'hD0D0_000B);
      settle();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t5 i%0d tie gnt0", i), 32'(gnt[i][0]), 32'd1);
         check($sformatf("t5 i%0d tie gnt1", i), 32'(gnt[i][1]), 32'd0);
         check($sformatf("t5 i%0d no rvalid0", i), 32'(rv[i][0]), 32'd0);
      end
      tick(); settle();
      for (int i = 0; i < 2; i++)
         check($sformatf("t5 i%0d next gnt1", i), 32'(gnt[i][1]), 32'd1);
      tick();

      // Test 6: port 0 reads held back-to-back, port 1 idle (RAM_LAT=1 instance).
      for (int j = 0; j < 3; j++) begin
         put2(1, 1'b1, 8'(4 + j), e_dat[j]);
         settle();
         tick();
      end
      oneshot = 1'b0;
      put(0, 0, 1'b0, 8'h04, 32'h0);
      for (int k = 0; k < 7; k++) begin
         settle();
         check($sformatf("t6 k%0d gnt0", k), 32'(gnt[0][0]), 32'(k == 0 || k == 2 || k == 4));
         check($sformatf("t6 k%0d rvalid0", k), 32'(rv[0][0]),
               32'(k == 2 || k == 4 || k == 6));
         if (k == 2 || k == 4 || k == 6)
            check($sformatf("t6 k%0d rdata0", k), rd[0][0], e_dat[k / 2 - 1]);
         tick();
         if (k == 0 || k == 2) ad[0][0] = 8'(4 + k / 2 + 1);
         if (k == 4) rq[0][0] = 1'b0;
      end
      oneshot = 1'b1;

      // Random traffic with occasional reset pulses.
      for (int n = 0; n < 4000; n++) begin
         tick();
         rst = ($urandom_range(0, 399) == 0);
         for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
               if (!rq[i][p] && $urandom_range(0, 2) == 0)
                  put(i, p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rq[i][0] = 1'b0; rq[i][1] = 1'b0;
      end
      repeat (6) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/selevy_ram_arbiter.md
Name: selevy_ram_arbiter

Overview:
- Two-port arbiter that shares the single-port data RAM of the selevy core between requesters.
- Port 0 is the core load/store unit; port 1 is a debug/DMA master that loads or inspects RAM contents.
- Serialises accesses with round-robin fairness, issues RAM commands, and returns read data to the owning port.
- Sits between the requesters and the RAM instance inside the selevy top.

Parameters:
ADDR_WIDTH, 8, RAM word-address width
DATA_WIDTH, 32, RAM word width
RAM_LAT, 1, RAM read latency in cycles (>=1); ram_rdata is valid RAM_LAT cycles after the command cycle

Ports:
CLK  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 access request; held with we0/addr0/wdata0 stable until gnt0
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  ADDR_WIDTH  port 0 word address
wdata0  input  DATA_WIDTH  port 0 write data
gnt0  output  1  port 0 accept pulse; command is issued this cycle
rvalid0  output  1  port 0 read-data valid pulse
rdata0  output  DATA_WIDTH  port 0 read data, valid while rvalid0=1
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
ram_en  output  1  RAM command strobe
ram_we  output  1  RAM write enable, qualified by ram_en
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data

Behaviour:
- States: IDLE, RD_WAIT. Register `last` holds the last-granted port.
- Reset (async, immediate): state=IDLE, last=1, rvalid0/1=0, rdata0/1=0, wait counter=0.
- While reset=1: gnt0/1=0 and ram_en=0.
- Winner in IDLE:
  - Only one req high: that port wins.
  - Both high: the port != last wins.
- Command issue (cycle T, combinational from IDLE + req):
  - ram_en=1; ram_we/addr/wdata taken from the winner.
  - gnt of the winner=1 for exactly this cycle.
  - last <= winner at the end of T.
- Write: completes in cycle T; state stays IDLE, so a new grant is possible at T+1. No rvalid.
- Read:
  - State -> RD_WAIT; counter loaded with RAM_LAT; owner port recorded.
  - Counter decrements each RD_WAIT cycle.
  - In the cycle where the counter equals 1 (cycle T+RAM_LAT), ram_rdata is captured into the owner's rdata register.
  - The owner's rvalid=1 for exactly cycle T+RAM_LAT+1; state returns to IDLE at that same edge.
  - A new grant may issue in cycle T+RAM_LAT+1, concurrent with rvalid.
- In RD_WAIT: no gnt, ram_en=0; requests are held off.
- rdataN keeps its last captured value when rvalidN=0. A non-owner's rdata never changes.
- ram_addr/ram_wdata/ram_we are don't-care when ram_en=0, and are driven to 0 for determinism.
- Fairness: with both ports requesting continuously, grants strictly alternate. Max wait for a port is one other access.
- A req dropped before its grant is a protocol violation; the arbiter simply re-evaluates each IDLE cycle, with no latching.
- Reset during RD_WAIT: the pending read is discarded and no rvalid is produced. After release, the first tie goes to port 0.
- The same port may be granted back-to-back only when the other port is not requesting.

Test Plan:
1. Reset release, req0=1 we0=1 addr0=8'h03 wdata0=32'hDEADBEEF only:
   - gnt0=1, ram_en=1, ram_we=1, ram_addr=8'h03 in the same cycle.
   - RAM[3]=DEADBEEF afterwards; no rvalid.
2. RAM_LAT=1, RAM[3]=DEADBEEF, req1 read addr1=8'h03 granted at cycle T:
   - rvalid1=1 and rdata1=32'hDEADBEEF in cycle T+2 only.
   - rvalid0 stays 0.
3. Both ports request writes continuously from reset:
   - Grants go gnt0, gnt1, gnt0, gnt1 on consecutive cycles.
4. Both ports request reads, RAM_LAT=2:
   - gnt0 at T, rvalid0 at T+3, gnt1 at T+3, rvalid1 at T+6.
   - No ram_en during T+1..T+2.
5. Read granted at T, reset pulsed at T+1:
   - No rvalid on either port; state=IDLE.
   - Next tied request grants port 0.
6. req0 read held, req1 absent for 3 accesses:
   - Port 0 granted at T, T+2, T+4 (RAM_LAT=1).
   - Each access returns its own RAM word.
